// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU debug sequencer: FSM states,
// command bytes, dump frame headers and the register snapshot layout.
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_DUMP = 3'd3,
        ST_SRST = 3'd4
    } dbg_state_e;

    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_SRST = 8'h58;

    localparam logic [7:0] HDR_OK  = 8'hA5;
    localparam logic [7:0] HDR_TMO = 8'h5A;

    localparam int DUMP_LEN = 8;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  ac;
        logic [7:0]  sp;
        logic [7:0]  xr;
        logic [7:0]  yr;
        logic [7:0]  sr;
    } dbg_snap_t;

    // Byte idx of the dump frame: header, PC hi, PC lo, AC, SP, XR, YR, SR.
    function automatic logic [7:0] frame_byte(input dbg_snap_t s,
                                              input logic [7:0] hdr,
                                              input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = hdr;
            3'd1:    b = s.pc[15:8];
            3'd2:    b = s.pc[7:0];
            3'd3:    b = s.ac;
            3'd4:    b = s.sp;
            3'd5:    b = s.xr;
            3'd6:    b = s.yr;
            default: b = s.sr;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dbg_tx_serializer.sv
// Streams the 8-byte register dump frame to the UART transmitter over
// valid/ready; started by a one-cycle pulse, reports done on the last accept.
module dbg_tx_serializer
    import cpu_dbg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] hdr,
    input  dbg_snap_t  snap,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       done
);

    localparam logic [2:0] LAST_IDX = 3'(DUMP_LEN - 1);

    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;
    logic       accept;

    always_comb begin
        accept  = valid_q & tx_ready;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        done    = 1'b0;
        if (start) begin
            idx_d   = 3'd0;
            valid_d = 1'b1;
            data_d  = frame_byte(snap, hdr, 3'd0);
        end else if (accept) begin
            if (idx_q == LAST_IDX) begin
                idx_d   = 3'd0;
                valid_d = 1'b0;
                done    = 1'b1;
            end else begin
                // Next byte goes out on the following cycle, no bubble.
                idx_d  = idx_q + 3'd1;
                data_d = frame_byte(snap, hdr, idx_q + 3'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Debug sequencer: decodes UART command bytes to run/halt/step/soft-reset the
// CPU and dumps a register snapshot frame after a step or dump request.
module cpu_debug_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int STEP_TIMEOUT = 1024,
    parameter int SRST_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] cpu_pc,
    input  logic [7:0]  cpu_ac,
    input  logic [7:0]  cpu_sp,
    input  logic [7:0]  cpu_xr,
    input  logic [7:0]  cpu_yr,
    input  logic [7:0]  cpu_sr,
    input  logic        cpu_step,
    output logic        cpu_ce,
    output logic        cpu_soft_rst,
    output logic        halted,
    output logic        busy
);

    localparam int CNT_MAX = (STEP_TIMEOUT > SRST_CYCLES) ? STEP_TIMEOUT : SRST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SRST_LAST = CNT_W'(SRST_CYCLES - 1);

    dbg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halt_pend_q, halt_pend_d;
    dbg_snap_t        snap_q, snap_d;
    logic [7:0]       hdr_q, hdr_d;
    logic             start_q, start_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             srst_q, srst_d;
    logic             halted_q, halted_d;
    logic             busy_q, busy_d;

    logic             snap_en;
    logic [7:0]       hdr_sel;
    logic             frame_done;
    logic             cmd_run, cmd_halt, cmd_step, cmd_dump, cmd_srst;
    logic             enter_dump;

    assign cmd_run  = rx_valid && (rx_data == CMD_RUN);
    assign cmd_halt = rx_valid && (rx_data == CMD_HALT);
    assign cmd_step = rx_valid && (rx_data == CMD_STEP);
    assign cmd_dump = rx_valid && (rx_data == CMD_DUMP);
    assign cmd_srst = rx_valid && (rx_data == CMD_SRST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_HALT;
        else     state_q <= state_d;
    end

    // Next-state logic, also decides when to snapshot and which header to use
    always_comb begin
        state_d = state_q;
        snap_en = 1'b0;
        hdr_sel = HDR_OK;
        case (state_q)
            ST_HALT: begin
                if (cmd_run) begin
                    state_d = ST_RUN;
                end else if (cmd_step) begin
                    state_d = ST_STEP;
                end else if (cmd_dump) begin
                    state_d = ST_DUMP;
                    snap_en = 1'b1;
                end else if (cmd_srst) begin
                    state_d = ST_SRST;
                end
            end
            ST_RUN: begin
                // Soft reset wins over a halt landing on the same boundary.
                if (cmd_srst) begin
                    state_d = ST_SRST;
                end else if ((halt_pend_q || cmd_halt) && cpu_step) begin
                    state_d = ST_HALT;
                    snap_en = 1'b1;
                end
            end
            ST_STEP: begin
                if (cpu_step) begin
                    state_d = ST_DUMP;
                    snap_en = 1'b1;
                end else if (cnt_q == STEP_LAST) begin
                    state_d = ST_DUMP;
                    snap_en = 1'b1;
                    hdr_sel = HDR_TMO;
                end
            end
            ST_DUMP: begin
                if (frame_done) state_d = ST_HALT;
            end
            ST_SRST: begin
                if (cnt_q == SRST_LAST) state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Counters, snapshot and frame launch
    always_comb begin
        enter_dump = (state_d == ST_DUMP) && (state_q != ST_DUMP);
        start_d    = enter_dump;
        hdr_d      = enter_dump ? hdr_sel : hdr_q;

        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == ST_STEP || state_q == ST_SRST)
            cnt_d = cnt_q + 1'b1;

        halt_pend_d = 1'b0;
        if (state_q == ST_RUN && state_d == ST_RUN)
            halt_pend_d = halt_pend_q || cmd_halt;

        snap_d = snap_q;
        if (snap_en) begin
            snap_d.pc = cpu_pc;
            snap_d.ac = cpu_ac;
            snap_d.sp = cpu_sp;
            snap_d.xr = cpu_xr;
            snap_d.yr = cpu_yr;
            snap_d.sr = cpu_sr;
        end
    end

    // Registered outputs follow the next state so they change on the same edge
    always_comb begin
        cpu_ce_d = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_SRST);
        srst_d   = (state_d == ST_SRST);
        halted_d = (state_d == ST_HALT);
        busy_d   = (state_d == ST_STEP) || (state_d == ST_DUMP) || (state_d == ST_SRST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
            snap_q      <= '0;
            hdr_q       <= 8'h00;
            start_q     <= 1'b0;
            cpu_ce_q    <= 1'b0;
            srst_q      <= 1'b0;
            halted_q    <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            snap_q      <= snap_d;
            hdr_q       <= hdr_d;
            start_q     <= start_d;
            cpu_ce_q    <= cpu_ce_d;
            srst_q      <= srst_d;
            halted_q    <= halted_d;
            busy_q      <= busy_d;
        end
    end

    dbg_tx_serializer u_ser (
        .clk      (clk),
        .rst      (rst),
        .start    (start_q),
        .hdr      (hdr_q),
        .snap     (snap_q),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .done     (frame_done)
    );

    assign cpu_ce       = cpu_ce_q;
    assign cpu_soft_rst = srst_q;
    assign halted       = halted_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed + randomized bench for cpu_debug_ctrl; expected frames and timing
// come from a byte-queue model of the command/dump behaviour.
module tb_cpu_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] cpu_pc;
    logic [7:0]  cpu_ac, cpu_sp, cpu_xr, cpu_yr, cpu_sr;
    logic        cpu_step;
    logic        cpu_ce, cpu_soft_rst, halted, busy;

    int checks   = 0;
    int failures = 0;
    int ce_cnt   = 0;
    int srst_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    cpu_debug_ctrl #(.STEP_TIMEOUT(16), .SRST_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .cpu_pc       (cpu_pc),
        .cpu_ac       (cpu_ac),
        .cpu_sp       (cpu_sp),
        .cpu_xr       (cpu_xr),
        .cpu_yr       (cpu_yr),
        .cpu_sr       (cpu_sr),
        .cpu_step     (cpu_step),
        .cpu_ce       (cpu_ce),
        .cpu_soft_rst (cpu_soft_rst),
        .halted       (halted),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every wait goes through here so cpu_ce / soft reset high-cycles are tallied.
    task automatic step_cycle();
        @(negedge clk);
        if (cpu_ce === 1'b1) ce_cnt++;
        if (cpu_soft_rst === 1'b1) srst_cnt++;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step_cycle();
        rx_valid = 1'b0;
    endtask

    task automatic set_regs(input logic [15:0] pc, input logic [7:0] ac, sp, xr, yr, sr);
        cpu_pc = pc; cpu_ac = ac; cpu_sp = sp; cpu_xr = xr; cpu_yr = yr; cpu_sr = sr;
    endtask

    task automatic rand_regs();
        set_regs(16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom));
    endtask

    // Expected frame from the register values the CPU shows right now.
    task automatic build_frame(input logic [7:0] hdr);
        exp_q.delete();
        exp_q.push_back(hdr);
        exp_q.push_back(cpu_pc[15:8]);
        exp_q.push_back(cpu_pc[7:0]);
        exp_q.push_back(cpu_ac);
        exp_q.push_back(cpu_sp);
        exp_q.push_back(cpu_xr);
        exp_q.push_back(cpu_yr);
        exp_q.push_back(cpu_sr);
    endtask

    // Gathers handshaken bytes; checks that a stalled byte is held stable.
    // With scramble set, live registers churn once the frame is on the wire.
    task automatic collect(input bit rand_ready, input bit scramble);
        bit         stall;
        logic [7:0] last;
        got_q.delete();
        stall = 1'b0;
        last  = 8'h00;
        for (int cyc = 0; cyc < 300 && got_q.size() < 8; cyc++) begin
            if (stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, last);
            end
            tx_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (tx_valid && scramble) rand_regs();
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            stall = tx_valid && !tx_ready;
            last  = tx_data;
            step_cycle();
        end
        tx_ready = 1'b1;
        chk("frame_len", got_q.size(), 8);
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_txv_after"}, tx_valid, 0);
        chk({tag, "_halted_after"}, halted, 1);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int hk;
        int acc;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        cpu_step = 1'b0;
        set_regs(16'h6789, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5);

        // Reset values
        step_cycle();
        step_cycle();
        chk("rst_halted", halted, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ce", cpu_ce, 0);
        chk("rst_srst", cpu_soft_rst, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);
        rst = 1'b0;
        step_cycle();

        // Dump from HALT: CPU never clocked
        ce_cnt = 0;
        build_frame(8'hA5);
        send(8'h44);
        chk("dump_busy", busy, 1);
        collect(1'b0, 1'b0);
        check_frame("dump");
        chk("dump_ce_cycles", ce_cnt, 0);

        // Step with cpu_step already high: one CE cycle, then OK frame
        rand_regs();
        build_frame(8'hA5);
        cpu_step = 1'b1;
        ce_cnt   = 0;
        send(8'h53);
        chk("step_ce", cpu_ce, 1);
        chk("step_busy", busy, 1);
        collect(1'b1, 1'b1);
        cpu_step = 1'b0;
        check_frame("step");
        chk("step_ce_cycles", ce_cnt, 1);

        // Step timeout: CE high for STEP_TIMEOUT cycles, timeout header
        rand_regs();
        build_frame(8'h5A);
        ce_cnt = 0;
        send(8'h53);
        collect(1'b1, 1'b1);
        check_frame("tmo");
        chk("tmo_ce_cycles", ce_cnt, 16);

        // Run, step pulses every 5 cycles, halt lands before/at the pulse at k=9
        send(8'h52);
        chk("run_ce", cpu_ce, 1);
        chk("run_halted", halted, 0);
        hk = $urandom_range(5, 9);
        for (int k = 0; k < 13; k++) begin
            cpu_step = (k % 5 == 4);
            rx_data  = 8'h48;
            rx_valid = (k == hk);
            step_cycle();
            rx_valid = 1'b0;
            chk($sformatf("run_ce_k%0d", k), cpu_ce, (k < 9));
            chk($sformatf("run_txv_k%0d", k), tx_valid, 0);
        end
        cpu_step = 1'b0;
        chk("run_halted_end", halted, 1);
        chk("run_busy_end", busy, 0);

        // Soft reset from HALT; a run command during it is dropped
        srst_cnt = 0;
        ce_cnt   = 0;
        send(8'h58);
        chk("srst_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            rx_data  = 8'h52;
            rx_valid = (i == 1);
            step_cycle();
            rx_valid = 1'b0;
        end
        chk("srst_cycles", srst_cnt, 4);
        chk("srst_ce_cycles", ce_cnt, 4);
        chk("srst_halted", halted, 1);
        chk("srst_ce_end", cpu_ce, 0);

        // Pending halt is cleared by a soft reset issued from RUN
        send(8'h52);
        send(8'h48);
        chk("pend_still_run", cpu_ce, 1);
        srst_cnt = 0;
        send(8'h58);
        repeat (6) step_cycle();
        chk("pend_srst_cycles", srst_cnt, 4);
        chk("pend_srst_halted", halted, 1);
        send(8'h52);
        cpu_step = 1'b1;
        step_cycle();
        cpu_step = 1'b0;
        step_cycle();
        chk("pend_cleared_ce", cpu_ce, 1);
        cpu_step = 1'b1;
        send(8'h48);
        cpu_step = 1'b0;
        chk("simul_halt_ce", cpu_ce, 0);
        chk("simul_halt_halted", halted, 1);

        // Randomized dumps with random backpressure and churning live registers
        for (int n = 0; n < 4; n++) begin
            rand_regs();
            build_frame(8'hA5);
            send(8'h44);
            collect(1'b1, 1'b1);
            check_frame($sformatf("rdump%0d", n));
        end

        // Stall on byte 2, then asynchronous reset mid-frame
        set_regs(16'h6789, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5);
        send(8'h44);
        acc = 0;
        tx_ready = 1'b1;
        for (int c = 0; c < 30 && acc < 2; c++) begin
            if (tx_valid) acc++;
            step_cycle();
        end
        tx_ready = 1'b0;
        chk("stall_reached", acc, 2);
        for (int i = 0; i < 10; i++) begin
            chk("stall_txv", tx_valid, 1);
            chk("stall_txd", tx_data, 8'h89);
            step_cycle();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_txv", tx_valid, 0);
        chk("arst_halted", halted, 1);
        chk("arst_busy", busy, 0);
        chk("arst_txd", tx_data, 0);
        step_cycle();
        rst = 1'b0;
        tx_ready = 1'b1;
        step_cycle();
        chk("post_rst_txv", tx_valid, 0);

        // Fresh frame after reset starts from the header again
        build_frame(8'hA5);
        send(8'h44);
        collect(1'b0, 1'b0);
        check_frame("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_debug_ctrl.md
Name: cpu_debug_ctrl

Overview:
Debug sequencer for the CPU core on the txrx build. It takes single-byte commands from the UART receiver and gates the CPU clock enable to run, halt or single-step it, and it drives the CPU soft reset. After a step or an explicit dump request it snapshots the CPU register file (PC, AC, SP, XR, YR, SR) and serialises an 8-byte frame to the UART transmitter over a valid/ready handshake.

Parameters:
STEP_TIMEOUT, 1024, max cpu_ce cycles in STEP without cpu_step before a forced abort dump
SRST_CYCLES, 4, cycles cpu_soft_rst is held high per 'X' command

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  8  received command byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
cpu_pc  in  16  CPU PC
cpu_ac, cpu_sp, cpu_xr, cpu_yr, cpu_sr  in  8 each  CPU registers
cpu_step  in  1  CPU at instruction boundary this cycle
cpu_ce  out  1  CPU clock enable
cpu_soft_rst  out  1  CPU soft reset
halted  out  1  controller in HALT
busy  out  1  STEP, DUMP or SRST in progress

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state HALT, cpu_ce=0, cpu_soft_rst=0, tx_valid=0, tx_data=0x00, halted=1, busy=0, snapshot=0, counters=0. All outputs are registered.
- Commands: 'R'=0x52 run, 'H'=0x48 halt, 'S'=0x53 step, 'D'=0x44 dump, 'X'=0x58 soft reset. Any other byte is ignored.
- HALT: cpu_ce=0.
  - 'R' -> RUN.
  - 'S' -> STEP.
  - 'D' -> snapshot, then DUMP with header 0xA5.
  - 'X' -> SRST.
  - 'H' -> no-op.
- RUN: cpu_ce=1.
  - 'H' sets halt_pending.
  - On the first cycle with (halt_pending or 'H' this cycle) and cpu_step=1: snapshot, go to HALT. cpu_ce is 0 from the next edge. No frame is sent.
  - 'X' -> SRST (clears halt_pending). 'R', 'S', 'D' are ignored.
- STEP: cpu_ce=1 from the entry edge.
  - Timeout counter increments each STEP cycle.
  - cpu_step=1 -> snapshot, DUMP with header 0xA5. cpu_ce=1 for exactly one cycle if cpu_step is already high.
  - Counter reaches STEP_TIMEOUT-1 with no cpu_step -> snapshot, DUMP with header 0x5A.
  - All rx bytes are dropped.
- DUMP: cpu_ce=0.
  - Frame order: header, PC[15:8], PC[7:0], AC, SP, XR, YR, SR (8 bytes).
  - Byte 0 is presented on the cycle after entering DUMP.
  - tx_valid stays high and tx_data stays stable until tx_valid & tx_ready. The next byte is presented on the following cycle (no bubble required; one allowed).
  - After byte 7 is accepted: tx_valid=0, go to HALT.
  - rx bytes are dropped.
- SRST: cpu_soft_rst=1 and cpu_ce=1 for exactly SRST_CYCLES cycles, then both go to 0 and the state goes to HALT. rx bytes are dropped.
- Snapshot: all six registers are captured in the same cycle. The frame uses only snapshot values, never live inputs.
- Status outputs: halted = (state==HALT). busy = state in {STEP, DUMP, SRST}.
- Simultaneous rx_valid and cpu_step in RUN with 'H': halt takes effect that cycle.
- rst asserted mid-operation: all outputs go to reset values immediately (asynchronously). A partial frame is abandoned, not resumed.

Decomposition:
- Package cpu_dbg_pkg:
  - state enum {HALT, RUN, STEP, DUMP, SRST}
  - command byte constants
  - HDR_OK=0xA5, HDR_TMO=0x5A
  - DUMP_LEN=8
- Sub-module dbg_tx_serializer: holds the 8-byte frame mux, 3-bit byte index and valid/ready logic. It has a start/done interface to the main FSM.

Test Plan:
- rst, inputs PC=0x6789 AC=A1 SP=B2 XR=C3 YR=D4 SR=E5, tx_ready=1, send 0x44 -> frame A5 67 89 A1 B2 C3 D4 E5; halted=1 after; cpu_ce never 1.
- cpu_step tied 1, send 0x53 -> cpu_ce high exactly 1 cycle, busy=1, then frame A5 67 89 A1 B2 C3 D4 E5.
- STEP_TIMEOUT=16, cpu_step=0, send 0x53 -> cpu_ce high 16 cycles, then frame with header 0x5A.
- Send 0x52, cpu_step pulses every 5 cycles, send 0x48 mid-interval -> cpu_ce drops on the edge after the next pulse; halted=1; tx_valid stays 0.
- SRST_CYCLES=4, send 0x58 -> cpu_soft_rst and cpu_ce high 4 cycles, then HALT; a 0x52 sent during SRST is ignored.
- During dump, hold tx_ready=0 for 10 cycles on byte 2 -> tx_data holds 0x89 with tx_valid=1; then assert rst -> tx_valid=0 and halted=1 without waiting for a clock edge.
